fetch_stage: RTL and testbench

Instruction fetch stage of the core. It owns the program counter, starting at `BOOT_ADDR`, and reads instructions through a req/ack handshake to instruction memory. Each fetched word goes into a single-entry output register that feeds the decode stage. Branch/jump redirects from execute and exception redirects flush the stage and restart fetch at the new address.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches through imem req/ack into a one-entry decode register.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned branch targets redirect to EXCEP_ADDR.
module fetch_stage #(
   parameter int                    INSTR_SIZE = 32,
   parameter int                    ADDR_SIZE  = 32,
   parameter logic [ADDR_SIZE-1:0]  BOOT_ADDR  = 32'h00001000,
   parameter logic [ADDR_SIZE-1:0]  EXCEP_ADDR = 32'h00002000,
   parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h00000000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_SIZE-1:0]  imem_addr,
   input  logic                  imem_ack,
   input  logic [INSTR_SIZE-1:0] imem_rdata,
   output logic                  de_valid,
   output logic [INSTR_SIZE-1:0] de_instr,
   output logic [ADDR_SIZE-1:0]  de_pc,
   input  logic                  de_stall,
   input  logic                  br_taken,
   input  logic [ADDR_SIZE-1:0]  br_target,
   input  logic                  excep,
   output logic                  excep_misalign,
   output logic [1:0]            fsm_state
);

   // Handshake: imem_req and imem_addr rise together and are held until the cycle imem_ack
   // is seen (ack may come in the same cycle as req); decode takes de_instr when de_valid && !de_stall.
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   pc_q;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic                   pending_q;
   logic                   redirect;
   logic                   misalign_hit;
   logic [ADDR_SIZE-1:0]   redirect_target;
   logic                   accept;
   logic                   transfer;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_q;

   assign misalign_hit = br_taken && !excep && (br_target[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_hit;
   end

   assign excep_misalign = misalign_q;
`else
   assign misalign_hit   = 1'b0;
   assign excep_misalign = 1'b0;
`endif

   assign redirect        = excep || br_taken;
   assign redirect_target = (excep || misalign_hit) ? EXCEP_ADDR : br_target;

   // An outstanding request keeps its captured address even after a redirect moves the PC.
   assign imem_addr = pending_q ? addr_q : pc_q;
   assign transfer  = de_valid && !de_stall;
   assign accept    = (state_q == S_FETCH) && imem_req && imem_ack && !redirect;
   assign fsm_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            imem_req = pending_q || !de_valid || !de_stall;
            if (redirect && imem_req && !imem_ack) state_d = S_DROP;
         end
         S_DROP: begin
            // Stale request still has to complete; its data is thrown away.
            imem_req = 1'b1;
            if (imem_ack) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= BOOT_ADDR;
         addr_q    <= BOOT_ADDR;
         pending_q <= 1'b0;
         de_valid  <= 1'b0;
         de_instr  <= NOP_INSTR;
         de_pc     <= BOOT_ADDR;
      end else begin
         pending_q <= imem_req && !imem_ack;
         addr_q    <= imem_addr;
         if (redirect) begin
            pc_q     <= redirect_target;
            de_valid <= 1'b0;
            de_instr <= NOP_INSTR;
         end else if (accept) begin
            pc_q     <= pc_q + ADDR_SIZE'(4);
            de_valid <= 1'b1;
            de_instr <= imem_rdata;
            de_pc    <= imem_addr;
         end else if (transfer) begin
            de_valid <= 1'b0;
            de_instr <= NOP_INSTR;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked by a transaction-level model.
module tb_fetch_stage;

   localparam logic [31:0] BOOT = 32'h0000_1000;
   localparam logic [31:0] EXC  = 32'h0000_2000;
   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] MASK = 32'hFFFF_0000;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        de_valid;
   logic [31:0] de_instr, de_pc;
   logic        de_stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic        excep = 1'b0;
   logic        excep_misalign;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_fails  = 0;
   int mem_lat  = 0;
   int wait_cnt;

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .de_valid(de_valid), .de_instr(de_instr), .de_pc(de_pc), .de_stall(de_stall),
      .br_taken(br_taken), .br_target(br_target), .excep(excep),
      .excep_misalign(excep_misalign), .fsm_state(fsm_state)
   );

   // ---------------- clock / memory ----------------
   always #5 clk = ~clk;

   assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
   assign imem_rdata = imem_addr ^ MASK;

   always @(posedge clk or posedge rst) begin
      if (rst)                       wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else                           wait_cnt <= 0;
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_and_release();
      next_cycle();
      rst = 1'b1; de_stall = 1'b0; br_taken = 1'b0; excep = 1'b0; mem_lat = 0;
      next_cycle();
      rst = 1'b0;
   endtask

   // ---------------- scoreboard / reference model ----------------
   logic [31:0] exp_q[$];   // addresses decode must receive, in order
   logic [31:0] m_req_pc, m_prev_addr, m_prev_de_pc, m_prev_de_instr;
   bit          m_pending, m_stale, m_prev_redirect, m_prev_accept, m_prev_hold, m_exp_mis;
   int          m_since_rst;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_req", imem_req, 0);
            check("rst_valid", de_valid, 0);
            check("rst_mis", excep_misalign, 0);
            exp_q.delete();
            exp_q.push_back(BOOT);
            m_req_pc = BOOT; m_pending = 0; m_stale = 0; m_prev_redirect = 0;
            m_prev_accept = 0; m_prev_hold = 0; m_exp_mis = 0; m_since_rst = 0;
         end else begin
            logic        redir, acc, mis_now;
            logic [31:0] tgt;
            check("mon_mis", excep_misalign, m_exp_mis);
            if (m_since_rst == 0) check("mon_idle_req", imem_req, 0);
            else check("mon_req", imem_req, m_pending || !de_valid || !de_stall);
            if (m_pending) check("mon_addr_hold", imem_addr, m_prev_addr);
            else if (imem_req) check("mon_addr", imem_addr, m_req_pc);
            if (m_prev_redirect) check("mon_flush", de_valid, 0);
            if (m_pending) check("mon_empty_while_req", de_valid, 0);
            if (m_prev_accept) begin
               check("mon_lat_valid", de_valid, 1);
               check("mon_lat_pc", de_pc, m_prev_addr);
            end
            if (m_prev_hold) begin
               check("mon_hold_valid", de_valid, 1);
               check("mon_hold_pc", de_pc, m_prev_de_pc);
               check("mon_hold_instr", de_instr, m_prev_de_instr);
            end
            if (!de_valid) check("mon_nop", de_instr, NOP);
            if (de_valid && !de_stall) begin
               check("mon_xfer_pc", de_pc, exp_q[0]);
               check("mon_xfer_instr", de_instr, exp_q[0] ^ MASK);
               exp_q[0] = exp_q[0] + 32'd4;
            end
            redir   = excep || br_taken;
            mis_now = ALIGN_EN && br_taken && !excep && (br_target[1:0] != 2'b00);
            tgt     = (excep || mis_now) ? EXC : br_target;
            acc     = imem_req && imem_ack && !redir && !m_stale;
            if (acc) m_req_pc = m_req_pc + 32'd4;
            if (redir) begin
               m_req_pc = tgt;
               exp_q[0] = tgt;
            end
            m_stale         = (imem_req && !imem_ack) ? (m_stale || redir) : 1'b0;
            m_pending       = imem_req && !imem_ack;
            m_prev_addr     = imem_addr;
            m_prev_redirect = redir;
            m_prev_accept   = acc;
            m_prev_hold     = de_valid && de_stall && !redir;
            m_prev_de_pc    = de_pc;
            m_prev_de_instr = de_instr;
            m_exp_mis       = mis_now;
            m_since_rst++;
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      // Reset values and zero-wait stream
      @(negedge clk);
      check("reset_addr", imem_addr, BOOT);
      check("reset_instr", de_instr, NOP);
      check("reset_de_pc", de_pc, BOOT);
      next_cycle(); rst = 1'b0;
      @(negedge clk); check("idle_req", imem_req, 0);
      next_cycle(); @(negedge clk);
      check("s1_req", imem_req, 1); check("s1_addr", imem_addr, 32'h1000); check("s1_valid", de_valid, 0);
      next_cycle(); @(negedge clk);
      check("s2_addr", imem_addr, 32'h1004); check("s2_valid", de_valid, 1);
      check("s2_pc", de_pc, 32'h1000); check("s2_instr", de_instr, 32'hFFFF1000);
      next_cycle(); @(negedge clk);
      check("s3_addr", imem_addr, 32'h1008); check("s3_pc", de_pc, 32'h1004);
      next_cycle(); @(negedge clk);
      check("s4_pc", de_pc, 32'h1008);

      // Decode stall with 0x1004 held
      reset_and_release();
      next_cycle(); next_cycle();
      for (int i = 0; i < 3; i++) begin
         next_cycle(); de_stall = 1'b1; @(negedge clk);
         check("stall_req", imem_req, 0);
         check("stall_pc", de_pc, 32'h1004);
         check("stall_instr", de_instr, 32'hFFFF1004);
      end
      next_cycle(); de_stall = 1'b0; @(negedge clk);
      check("resume_req", imem_req, 1); check("resume_addr", imem_addr, 32'h1008);
      next_cycle(); @(negedge clk);
      check("resume_pc", de_pc, 32'h1008); check("s7_addr", imem_addr, 32'h100C);

      // Branch while a slow request to 0x1010 is outstanding
      next_cycle(); mem_lat = 2; @(negedge clk);
      check("br_req_addr", imem_addr, 32'h1010); check("br_no_ack", imem_ack, 0);
      next_cycle(); br_taken = 1'b1; br_target = 32'h1400; @(negedge clk);
      check("br_hold_addr", imem_addr, 32'h1010);
      next_cycle(); br_taken = 1'b0; @(negedge clk);
      check("drop_req", imem_req, 1); check("drop_addr", imem_addr, 32'h1010);
      check("drop_ack", imem_ack, 1); check("drop_valid", de_valid, 0);
      next_cycle(); mem_lat = 0; @(negedge clk);
      check("tgt_addr", imem_addr, 32'h1400); check("tgt_valid", de_valid, 0);

      // excep + br_taken together with an ack
      next_cycle(); excep = 1'b1; br_taken = 1'b1; br_target = 32'h1400; @(negedge clk);
      check("sim_pc", de_pc, 32'h1400); check("sim_ack", imem_ack, 1);
      next_cycle(); excep = 1'b0; br_taken = 1'b0; @(negedge clk);
      check("sim_addr", imem_addr, EXC); check("sim_valid", de_valid, 0);
      next_cycle(); @(negedge clk);
      check("exc_pc", de_pc, EXC); check("exc_valid", de_valid, 1);

      // Misaligned branch target
      next_cycle(); br_taken = 1'b1; br_target = 32'h1402; @(negedge clk);
      next_cycle(); br_taken = 1'b0; @(negedge clk);
      check("mis_addr", imem_addr, ALIGN_EN ? EXC : 32'h1402);
      check("mis_flag", excep_misalign, ALIGN_EN ? 32'd1 : 32'd0);
      next_cycle(); @(negedge clk);
      check("mis_flag_drop", excep_misalign, 0);
      check("mis_pc", de_pc, ALIGN_EN ? EXC : 32'h1402);

      // Reset while the request to 0x1008 is outstanding
      reset_and_release();
      next_cycle(); next_cycle();
      next_cycle(); mem_lat = 3; @(negedge clk);
      check("mid_addr", imem_addr, 32'h1008); check("mid_no_ack", imem_ack, 0);
      next_cycle(); rst = 1'b1; @(negedge clk);
      check("mid_rst_req", imem_req, 0); check("mid_rst_valid", de_valid, 0);
      next_cycle(); rst = 1'b0; mem_lat = 0; @(negedge clk);
      check("mid_idle_req", imem_req, 0);
      next_cycle(); @(negedge clk);
      check("restart_addr", imem_addr, BOOT); check("restart_req", imem_req, 1);

      // Randomized traffic
      reset_and_release();
      for (int i = 0; i < 3000; i++) begin
         int r;
         next_cycle();
         br_taken = 1'b0; excep = 1'b0;
         de_stall = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(0, 3);
         r = $urandom_range(0, 99);
         if (r < 5) begin
            br_taken  = 1'b1;
            br_target = 32'h1000 + ($urandom_range(0, 1023) << 2)
                      + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
         end
         if (r >= 4 && r < 7) excep = 1'b1;
      end
      next_cycle(); br_taken = 1'b0; excep = 1'b0; de_stall = 1'b0;
      repeat (8) next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
